// File: rtl/cpu_v2_pkg.sv
// rtl/cpu_v2_pkg.sv - shared opcode/state types and instruction field offsets for cpu_v2_core
package cpu_v2_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_XOR  = 4'd5,
        OP_ADDI = 4'd6,
        OP_IN   = 4'd7,
        OP_OUT  = 4'd8,
        OP_JMP  = 4'd9,
        OP_BZ   = 4'd10,
        OP_BNZ  = 4'd11,
        OP_HALT = 4'd12,
        OP_R13  = 4'd13,
        OP_R14  = 4'd14,
        OP_R15  = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_OUT = 2'd1,
        ST_HALTED   = 2'd2
    } state_e;

    function automatic int instr_width(input int ow, input int aw, input int bw);
        return ow + aw + bw;
    endfunction

    function automatic int opcode_lsb(input int aw, input int bw);
        return aw + bw;
    endfunction

    function automatic int rd_lsb(input int bw);
        return bw;
    endfunction

    function automatic int ra_lsb(input int aw);
        return aw;
    endfunction

endpackage

// File: rtl/register_file_v2.sv
// rtl/register_file_v2.sv - 3-read/1-write register file, r0 hardwired to zero
module register_file_v2 #(
    parameter int BUS_WIDTH      = 8,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      n_reset,
    input  logic [REG_ADDR_WIDTH-1:0] ra_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rb_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [BUS_WIDTH-1:0]      ra_data_o,
    output logic [BUS_WIDTH-1:0]      rb_data_o,
    output logic [BUS_WIDTH-1:0]      rd_data_o,
    input  logic                      we_i,
    input  logic [REG_ADDR_WIDTH-1:0] wa_i,
    input  logic [BUS_WIDTH-1:0]      wd_i
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [BUS_WIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
    assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];
    assign rd_data_o = (rd_addr_i == '0) ? '0 : regs_q[rd_addr_i];

endmodule

// File: rtl/cpu_v2_core.sv
// rtl/cpu_v2_core.sv - single-cycle RISC core with synchronised IN strobe and OUT handshake
module cpu_v2_core
    import cpu_v2_pkg::*;
#(
    parameter  int OPCODE_WIDTH     = 4,
    parameter  int REG_ADDR_WIDTH   = 3,
    parameter  int BUS_WIDTH        = 8,
    parameter  int INSTR_ADDR_WIDTH = 5,
    localparam int INSTR_WIDTH      = OPCODE_WIDTH + REG_ADDR_WIDTH + BUS_WIDTH
) (
    input  logic                        clock,
    input  logic                        n_reset,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
    input  logic [INSTR_WIDTH-1:0]      instr_data,
    input  logic [BUS_WIDTH-1:0]        sw,
    input  logic                        ready_in,
    output logic [BUS_WIDTH-1:0]        out_port,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        halted
);
    localparam int OP_LSB = opcode_lsb(REG_ADDR_WIDTH, BUS_WIDTH);
    localparam int RD_LSB = rd_lsb(BUS_WIDTH);
    localparam int RA_LSB = ra_lsb(REG_ADDR_WIDTH);

    state_e                      state_q, state_d;
    logic [INSTR_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [BUS_WIDTH-1:0]        out_port_q, out_port_d;
    logic                        out_valid_q, out_valid_d;
    logic                        rdy_s1_q, rdy_s2_q, rdy_s3_q;
    logic [BUS_WIDTH-1:0]        sw_s1_q, sw_s2_q;

    logic [OPCODE_WIDTH-1:0]     opc_raw;
    opcode_e                     op;
    logic [REG_ADDR_WIDTH-1:0]   rd_f, ra_f, rb_f;
    logic [BUS_WIDTH-1:0]        imm;
    logic [INSTR_ADDR_WIDTH-1:0] target;
    logic [BUS_WIDTH-1:0]        ra_data, rb_data, rd_data;
    logic                        rf_we;
    logic [BUS_WIDTH-1:0]        rf_wd;
    logic                        in_strobe;

    assign opc_raw = instr_data[OP_LSB +: OPCODE_WIDTH];
    assign rd_f    = instr_data[RD_LSB +: REG_ADDR_WIDTH];
    assign ra_f    = instr_data[RA_LSB +: REG_ADDR_WIDTH];
    assign rb_f    = instr_data[0 +: REG_ADDR_WIDTH];
    assign imm     = instr_data[BUS_WIDTH-1:0];
    assign target  = instr_data[INSTR_ADDR_WIDTH-1:0];

    // Opcodes beyond the 4-bit enum space (wider OPCODE_WIDTH) decode as NOP.
    always_comb begin
        op = OP_NOP;
        if ((opc_raw >> 4) == '0) begin
            op = opcode_e'(opc_raw[3:0]);
        end
    end

    register_file_v2 #(
        .BUS_WIDTH      (BUS_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_rf (
        .clock     (clock),
        .n_reset   (n_reset),
        .ra_addr_i (ra_f),
        .rb_addr_i (rb_f),
        .rd_addr_i (rd_f),
        .ra_data_o (ra_data),
        .rb_data_o (rb_data),
        .rd_data_o (rd_data),
        .we_i      (rf_we),
        .wa_i      (rd_f),
        .wd_i      (rf_wd)
    );

    // sw shares the ready_in depth so data is settled when the strobe fires.
    assign in_strobe = rdy_s2_q & ~rdy_s3_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_port_d  = out_port_q;
        out_valid_d = out_valid_q;
        rf_we       = 1'b0;
        rf_wd       = '0;
        unique case (state_q)
            ST_RUN: begin
                pc_d = pc_q + INSTR_ADDR_WIDTH'(1);
                case (op)
                    OP_LDI:  begin rf_we = 1'b1; rf_wd = imm;               end
                    OP_ADD:  begin rf_we = 1'b1; rf_wd = ra_data + rb_data; end
                    OP_SUB:  begin rf_we = 1'b1; rf_wd = ra_data - rb_data; end
                    OP_AND:  begin rf_we = 1'b1; rf_wd = ra_data & rb_data; end
                    OP_XOR:  begin rf_we = 1'b1; rf_wd = ra_data ^ rb_data; end
                    OP_ADDI: begin rf_we = 1'b1; rf_wd = rd_data + imm;     end
                    OP_IN: begin
                        if (in_strobe) begin
                            rf_we = 1'b1;
                            rf_wd = sw_s2_q;
                        end else begin
                            pc_d = pc_q;
                        end
                    end
                    OP_OUT: begin
                        out_port_d  = ra_data;
                        out_valid_d = 1'b1;
                        state_d     = ST_WAIT_OUT;
                    end
                    OP_JMP: pc_d = target;
                    OP_BZ:  if (rd_data == '0) pc_d = target;
                    OP_BNZ: if (rd_data != '0) pc_d = target;
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALTED;
                    end
                    default: ;
                endcase
            end
            ST_WAIT_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            ST_HALTED: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_RUN;
            pc_q        <= '0;
            out_port_q  <= '0;
            out_valid_q <= 1'b0;
            rdy_s1_q    <= 1'b0;
            rdy_s2_q    <= 1'b0;
            rdy_s3_q    <= 1'b0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_port_q  <= out_port_d;
            out_valid_q <= out_valid_d;
            rdy_s1_q    <= ready_in;
            rdy_s2_q    <= rdy_s1_q;
            rdy_s3_q    <= rdy_s2_q;
            sw_s1_q     <= sw;
            sw_s2_q     <= sw_s1_q;
        end
    end

    assign instr_addr = pc_q;
    assign out_port   = out_port_q;
    assign out_valid  = out_valid_q;
    assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_cpu_v2_core.sv
// tb/tb_cpu_v2_core.sv - scoreboard bench for cpu_v2_core
module tb_cpu_v2_core;
    import cpu_v2_pkg::*;

    logic        clock = 1'b0;
    logic        n_reset;
    logic [4:0]  instr_addr;
    logic [14:0] instr_data;
    logic [7:0]  sw;
    logic        ready_in;
    logic [7:0]  out_port;
    logic        out_valid;
    logic        out_ready;
    logic        halted;

    logic [14:0] rom [32];
    logic [7:0]  exp_q [$];
    int          total = 0;
    int          bad   = 0;

    cpu_v2_core dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .sw         (sw),
        .ready_in   (ready_in),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .halted     (halted)
    );

    assign instr_data = rom[instr_addr];

    always #5 clock = ~clock;

    function automatic logic [14:0] enc_i(input opcode_e op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [14:0] enc_r(input opcode_e op, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, 2'b00, ra, rb};
    endfunction

    function automatic logic [14:0] enc_j(input opcode_e op, input logic [2:0] rd, input logic [4:0] tgt);
        return {op, rd, 3'b000, tgt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output beat is checked against the scoreboard.
    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got 0x%0h expected nothing", out_port);
            end else begin
                chk("out_port", {24'd0, out_port}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rst_on();
        n_reset = 1'b0;
        #1;
    endtask

    task automatic release_rst();
        step(1);
        n_reset = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = '0;
    endtask

    task automatic wait_halt(input string name, input int budget, output int wraps);
        int          n;
        logic [4:0]  prev;
        n     = 0;
        wraps = 0;
        while (!halted && n < budget) begin
            prev = instr_addr;
            step(1);
            n++;
            if (prev == 5'd31 && !halted) begin
                wraps++;
                chk({name, "_wrap_to_0"}, instr_addr, 0);
            end
        end
        chk({name, "_halted"}, halted, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wraps;
        int n;
        int loops;

        n_reset   = 1'b0;
        ready_in  = 1'b0;
        sw        = 8'h00;
        out_ready = 1'b1;
        clear_rom();
        step(2);
        chk("rst_pc", instr_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_out_port", out_port, 0);

        // Basic ALU: r3=8, r4=0xFE
        rom[0] = enc_i(OP_LDI, 3'd1, 8'd5);
        rom[1] = enc_i(OP_LDI, 3'd2, 8'd3);
        rom[2] = enc_r(OP_ADD, 3'd3, 3'd1, 3'd2);
        rom[3] = enc_r(OP_SUB, 3'd4, 3'd2, 3'd1);
        rom[4] = enc_r(OP_OUT, 3'd0, 3'd3, 3'd0);
        rom[5] = enc_r(OP_OUT, 3'd0, 3'd4, 3'd0);
        rom[6] = enc_i(OP_HALT, 3'd0, 8'd0);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'hFE);
        release_rst();
        step(4);
        chk("t1_pc_after_4", instr_addr, 4);
        wait_halt("t1", 40, wraps);
        chk("t1_halt_pc", instr_addr, 6);
        chk("t1_drained", exp_q.size(), 0);

        // Wrap, r0 discard, AND/XOR
        rst_on();
        clear_rom();
        rom[0]  = enc_i(OP_LDI, 3'd1, 8'hFF);
        rom[1]  = enc_i(OP_ADDI, 3'd1, 8'h02);
        rom[2]  = enc_i(OP_LDI, 3'd0, 8'h07);
        rom[3]  = enc_r(OP_ADD, 3'd2, 3'd0, 3'd1);
        rom[4]  = enc_i(OP_LDI, 3'd3, 8'hF0);
        rom[5]  = enc_i(OP_LDI, 3'd4, 8'h3C);
        rom[6]  = enc_r(OP_AND, 3'd5, 3'd3, 3'd4);
        rom[7]  = enc_r(OP_XOR, 3'd6, 3'd3, 3'd4);
        rom[8]  = enc_r(OP_OUT, 3'd0, 3'd1, 3'd0);
        rom[9]  = enc_r(OP_OUT, 3'd0, 3'd2, 3'd0);
        rom[10] = enc_r(OP_OUT, 3'd0, 3'd0, 3'd0);
        rom[11] = enc_r(OP_OUT, 3'd0, 3'd5, 3'd0);
        rom[12] = enc_r(OP_OUT, 3'd0, 3'd6, 3'd0);
        rom[13] = enc_i(OP_HALT, 3'd0, 8'd0);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'hCC);
        release_rst();
        wait_halt("t2", 60, wraps);
        chk("t2_halt_pc", instr_addr, 13);
        chk("t2_drained", exp_q.size(), 0);

        // IN: early strobe dropped, later strobe takes 3 edges
        rst_on();
        clear_rom();
        rom[8]  = enc_i(OP_IN, 3'd1, 8'd0);
        rom[9]  = enc_r(OP_OUT, 3'd0, 3'd1, 3'd0);
        rom[10] = enc_i(OP_HALT, 3'd0, 8'd0);
        sw = 8'h5C;
        release_rst();
        step(1);
        ready_in = 1'b1;
        step(1);
        ready_in = 1'b0;
        n = 0;
        while (instr_addr != 5'd8 && n < 20) begin
            step(1);
            n++;
        end
        chk("t3_reach_in", instr_addr, 8);
        step(10);
        chk("t3_in_stalled", instr_addr, 8);
        sw = 8'hA5;
        ready_in = 1'b1;
        exp_q.push_back(8'hA5);
        step(2);
        chk("t3_pc_hold_2", instr_addr, 8);
        step(1);
        chk("t3_pc_adv_3", instr_addr, 9);
        wait_halt("t3", 20, wraps);
        chk("t3_halt_pc", instr_addr, 10);
        chk("t3_drained", exp_q.size(), 0);
        ready_in = 1'b0;

        // OUT backpressure
        rst_on();
        clear_rom();
        rom[0] = enc_i(OP_LDI, 3'd1, 8'h3C);
        rom[1] = enc_r(OP_OUT, 3'd0, 3'd1, 3'd0);
        rom[3] = enc_i(OP_HALT, 3'd0, 8'd0);
        out_ready = 1'b0;
        release_rst();
        step(2);
        chk("t4_valid_up", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t4_valid_hold", out_valid, 1);
            chk("t4_port_stable", out_port, 8'h3C);
            chk("t4_pc_frozen", instr_addr, 2);
        end
        exp_q.push_back(8'h3C);
        out_ready = 1'b1;
        step(1);
        chk("t4_valid_drop", out_valid, 0);
        chk("t4_pc_after_accept", instr_addr, 2);
        step(1);
        chk("t4_pc_resume", instr_addr, 3);
        wait_halt("t4", 10, wraps);
        chk("t4_halt_pc", instr_addr, 3);
        chk("t4_drained", exp_q.size(), 0);

        // Countdown loop with BNZ
        rst_on();
        clear_rom();
        rom[0] = enc_i(OP_LDI, 3'd1, 8'd3);
        rom[1] = enc_i(OP_ADDI, 3'd1, 8'hFF);
        rom[2] = enc_j(OP_BNZ, 3'd1, 5'd1);
        rom[3] = enc_i(OP_HALT, 3'd0, 8'd0);
        release_rst();
        n = 0;
        loops = 0;
        while (!halted && n < 50) begin
            if (instr_addr == 5'd2) loops++;
            step(1);
            n++;
        end
        chk("t5_loops", loops, 3);
        chk("t5_halted", halted, 1);
        chk("t5_pc", instr_addr, 3);
        step(5);
        chk("t5_pc_stays", instr_addr, 3);
        chk("t5_still_halted", halted, 1);

        // JMP 31 -> 0, BNZ both ways, BZ not taken
        rst_on();
        clear_rom();
        rom[0]  = enc_j(OP_BNZ, 3'd1, 5'd4);
        rom[1]  = enc_i(OP_LDI, 3'd1, 8'h42);
        rom[2]  = enc_j(OP_JMP, 3'd0, 5'd31);
        rom[31] = enc_j(OP_JMP, 3'd0, 5'd0);
        rom[4]  = enc_j(OP_BZ, 3'd1, 5'd7);
        rom[5]  = enc_r(OP_OUT, 3'd0, 3'd1, 3'd0);
        rom[6]  = enc_i(OP_HALT, 3'd0, 8'd0);
        rom[7]  = enc_i(OP_HALT, 3'd0, 8'd0);
        exp_q.push_back(8'h42);
        release_rst();
        wait_halt("t6a", 30, wraps);
        chk("t6a_wraps", wraps, 1);
        chk("t6a_halt_pc", instr_addr, 6);
        chk("t6a_drained", exp_q.size(), 0);

        // Sequential wrap 31 -> 0, BZ on r0 taken
        rst_on();
        clear_rom();
        rom[0] = enc_j(OP_BNZ, 3'd1, 5'd4);
        rom[1] = enc_i(OP_LDI, 3'd1, 8'h5A);
        rom[2] = enc_j(OP_JMP, 3'd0, 5'd30);
        rom[4] = enc_j(OP_BZ, 3'd0, 5'd6);
        rom[5] = enc_i(OP_HALT, 3'd0, 8'd0);
        rom[6] = enc_r(OP_OUT, 3'd0, 3'd1, 3'd0);
        rom[7] = enc_i(OP_HALT, 3'd0, 8'd0);
        exp_q.push_back(8'h5A);
        release_rst();
        wait_halt("t6b", 30, wraps);
        chk("t6b_wraps", wraps, 1);
        chk("t6b_halt_pc", instr_addr, 7);
        chk("t6b_drained", exp_q.size(), 0);

        // Reset during WAIT_OUT and during HALTED
        rst_on();
        clear_rom();
        rom[0] = enc_i(OP_LDI, 3'd1, 8'h3C);
        rom[1] = enc_r(OP_OUT, 3'd0, 3'd1, 3'd0);
        rom[2] = enc_i(OP_HALT, 3'd0, 8'd0);
        out_ready = 1'b0;
        release_rst();
        step(2);
        chk("t7_pending", out_valid, 1);
        rst_on();
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_pc", instr_addr, 0);
        chk("t7_rst_halted", halted, 0);
        out_ready = 1'b1;
        exp_q.push_back(8'h3C);
        release_rst();
        wait_halt("t7a", 20, wraps);
        chk("t7a_halt_pc", instr_addr, 2);
        rst_on();
        chk("t7_rst2_halted", halted, 0);
        chk("t7_rst2_pc", instr_addr, 0);
        exp_q.push_back(8'h3C);
        release_rst();
        wait_halt("t7b", 20, wraps);
        chk("t7b_halt_pc", instr_addr, 2);
        chk("t7_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
